// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared types and constants for the reset sequencer:
//   seq_state_e  - sequencer FSM states
//   DEF_*        - default timing / sizing constants
//   ERR_STAGE_W  - fixed width of the err_stage report
//   idx_w()      - stage index width (never less than 1 bit)
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [2:0] {
        STRETCH,
        RELEASE,
        WAIT_RDY,
        GAP,
        DONE
    } seq_state_e;

    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_STRETCH_CYC = 16;
    localparam int DEF_GAP_CYC     = 8;
    localparam int DEF_ACK_TIMEOUT = 255;
    localparam int DEF_CNT_W       = 8;

    localparam int ERR_STAGE_W     = 4;

    // $clog2(1) is 0, which would give a zero-width index register.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// -----------------------------------------------------------------------------
// rst_sequencer_if
// Bundles the sequencer's control and status signals.
//   sw_rst_req   - warm-reset request pulse (slave -> master)
//   stage_ready  - per-stage init-done (slave -> master)
//   stage_rst_n  - per-stage active-low resets (master -> slave)
//   all_ready    - every stage released, sequence complete
//   seq_busy     - sequence in progress
//   timeout_err  - sticky ready-timeout flag
//   err_stage    - index of the most recent timed-out stage
// master = the sequencer, slave = the blocks / software side.
// -----------------------------------------------------------------------------
interface rst_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    import rst_seq_pkg::*;

    logic                   sw_rst_req;
    logic [NUM_STAGES-1:0]  stage_ready;
    logic [NUM_STAGES-1:0]  stage_rst_n;
    logic                   all_ready;
    logic                   seq_busy;
    logic                   timeout_err;
    logic [ERR_STAGE_W-1:0] err_stage;

    modport master (
        input  sw_rst_req, stage_ready,
        output stage_rst_n, all_ready, seq_busy, timeout_err, err_stage
    );

    modport slave (
        output sw_rst_req, stage_ready,
        input  stage_rst_n, all_ready, seq_busy, timeout_err, err_stage
    );

endinterface

// File: rtl/rst_seq_timer.sv
// -----------------------------------------------------------------------------
// rst_seq_timer
// Clearable up-counter with a terminal-count compare. One instance serves the
// stretch, gap and ready-timeout phases; the owner selects tc_val per phase.
//   clk, sync_rst_n - clock, asynchronous active-high reset
//   clr             - synchronous clear (wins over en)
//   en              - count enable
//   tc_val          - terminal-count value to compare against
//   cnt             - current count
//   tc              - cnt == tc_val
// -----------------------------------------------------------------------------
module rst_seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             sync_rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk or posedge sync_rst_n) begin
        if (sync_rst_n)  cnt <= '0;
        else if (clr)    cnt <= '0;
        else if (en)     cnt <= cnt + 1'b1;
    end

    // Exact compare: the owner clears on every phase entry, so no wrap case.
    assign tc = (cnt == tc_val);

endmodule

// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
// Stretches the incoming synchronized reset, then releases NUM_STAGES block
// resets one at a time, waiting for each stage's ready (bounded by a timeout)
// plus a fixed gap before the next release. A warm-reset request reruns the
// whole sequence without clearing the error capture.
//   clk         - system clock
//   sync_rst_n  - asynchronous reset, active-high (despite the name)
//   bus         - rst_sequencer_if master: sw_rst_req/stage_ready in,
//                 stage_rst_n/all_ready/seq_busy/timeout_err/err_stage out
// -----------------------------------------------------------------------------
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int STRETCH_CYC = DEF_STRETCH_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              sync_rst_n,
    rst_sequencer_if.master   bus
);

    localparam int              IDX_W    = idx_w(NUM_STAGES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    seq_state_e             state, state_n;
    logic [IDX_W-1:0]       idx, idx_n;

    logic                   tmr_clr, tmr_en, tmr_tc;
    logic [CNT_W-1:0]       tmr_tc_val, tmr_cnt;

    logic                   rel_stage;   // release stage idx this edge
    logic                   to_hit;      // ready timeout this edge
    logic                   rdy_cur;

    logic [NUM_STAGES-1:0]  stage_rst_n_q;
    logic                   all_ready_q, seq_busy_q, timeout_err_q;
    logic [ERR_STAGE_W-1:0] err_stage_q;

    // Only the stage currently being waited on is looked at.
    assign rdy_cur = bus.stage_ready[idx];

    rst_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .clr        (tmr_clr),
        .en         (tmr_en),
        .tc_val     (tmr_tc_val),
        .cnt        (tmr_cnt),
        .tc         (tmr_tc)
    );

    always_comb begin
        tmr_tc_val = CNT_W'(STRETCH_CYC - 1);
        case (state)
            GAP:      tmr_tc_val = CNT_W'(GAP_CYC - 1);
            WAIT_RDY: tmr_tc_val = CNT_W'(ACK_TIMEOUT - 1);
            default:  tmr_tc_val = CNT_W'(STRETCH_CYC - 1);
        endcase
    end

    // FSM state and stage index registers
    always_ff @(posedge clk or posedge sync_rst_n) begin
        if (sync_rst_n) begin
            state <= STRETCH;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        rel_stage = 1'b0;
        to_hit    = 1'b0;
        if (bus.sw_rst_req) begin
            // Held request parks in STRETCH with the counter at zero.
            state_n = STRETCH;
            idx_n   = '0;
            tmr_clr = 1'b1;
        end else begin
            case (state)
                STRETCH: begin
                    if (tmr_tc) begin
                        state_n = RELEASE;
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_en  = 1'b1;
                    end
                end
                RELEASE: begin
                    rel_stage = 1'b1;
                    tmr_clr   = 1'b1;
                    state_n   = WAIT_RDY;
                end
                WAIT_RDY: begin
                    // A timeout flags the error, then advances as if ready
                    // had arrived so a dead stage never stalls the sequence.
                    if (rdy_cur || tmr_tc) begin
                        to_hit  = !rdy_cur;
                        tmr_clr = 1'b1;
                        state_n = (idx == LAST_IDX) ? DONE : GAP;
                    end else begin
                        tmr_en  = 1'b1;
                    end
                end
                GAP: begin
                    if (tmr_tc) begin
                        idx_n   = idx + 1'b1;
                        state_n = RELEASE;
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_en  = 1'b1;
                    end
                end
                DONE:    state_n = DONE;
                default: state_n = STRETCH;
            endcase
        end
    end

    // Output registers. Error capture is left alone by the warm reset.
    always_ff @(posedge clk or posedge sync_rst_n) begin
        if (sync_rst_n) begin
            stage_rst_n_q <= '0;
            all_ready_q   <= 1'b0;
            seq_busy_q    <= 1'b1;
            timeout_err_q <= 1'b0;
            err_stage_q   <= '0;
        end else if (bus.sw_rst_req) begin
            stage_rst_n_q <= '0;
            all_ready_q   <= 1'b0;
            seq_busy_q    <= 1'b1;
        end else begin
            if (rel_stage)
                stage_rst_n_q[idx] <= 1'b1;
            // Status trails DONE entry by one edge.
            all_ready_q <= (state == DONE);
            seq_busy_q  <= (state != DONE);
            if (to_hit) begin
                timeout_err_q <= 1'b1;
                err_stage_q   <= ERR_STAGE_W'(idx);
            end
        end
    end

    assign bus.stage_rst_n = stage_rst_n_q;
    assign bus.all_ready   = all_ready_q;
    assign bus.seq_busy    = seq_busy_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.err_stage   = err_stage_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rst_sequencer
// Two instances: a default 4-stage sequencer and a minimal 1-stage one
// (STRETCH_CYC=1, GAP_CYC=1). Expected output snapshots are queued with the
// absolute edge number at which they must hold and compared 1 ns after that
// edge.
// -----------------------------------------------------------------------------
module tb_rst_sequencer;

    logic clk  = 1'b0;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    rst_sequencer_if #(.NUM_STAGES(4)) bus1 ();
    rst_sequencer_if #(.NUM_STAGES(1)) bus2 ();

    rst_sequencer #(.NUM_STAGES(4)) dut1 (
        .clk        (clk),
        .sync_rst_n (rst1),
        .bus        (bus1.master)
    );

    rst_sequencer #(.NUM_STAGES(1), .STRETCH_CYC(1), .GAP_CYC(1)) dut2 (
        .clk        (clk),
        .sync_rst_n (rst2),
        .bus        (bus2.master)
    );

    typedef struct {
        int         at;
        bit         d2;
        logic [3:0] rn;
        logic       ar;
        logic       busy;
        logic       te;
        logic [3:0] es;
        string      nm;
    } exp_t;

    typedef struct {
        int         off;
        logic [3:0] rn;
        logic       ar;
        logic       busy;
    } vec_t;

    exp_t sb[$];
    vec_t seq_tbl[11];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: got rst_n/ar/busy/terr/estg=%b want %b", nm, cyc, act, exp_v);
        end
    endtask

    function automatic logic [10:0] obs(input bit d2);
        if (d2)
            return {3'b000, bus2.stage_rst_n, bus2.all_ready, bus2.seq_busy,
                    bus2.timeout_err, bus2.err_stage};
        return {bus1.stage_rst_n, bus1.all_ready, bus1.seq_busy,
                bus1.timeout_err, bus1.err_stage};
    endfunction

    task automatic push(input bit d2, input int at, input logic [3:0] rn, input logic ar,
                        input logic busy, input logic te, input logic [3:0] es, input string nm);
        exp_t e;
        e.at = at; e.d2 = d2; e.rn = rn; e.ar = ar; e.busy = busy;
        e.te = te; e.es = es; e.nm = nm;
        sb.push_back(e);
    endtask

    // Full default sequence with every ready high, relative to a base edge.
    task automatic push_tbl(input int base, input logic te, input logic [3:0] es, input string nm);
        for (int i = 0; i < 11; i++)
            push(1'b0, base + seq_tbl[i].off, seq_tbl[i].rn, seq_tbl[i].ar, seq_tbl[i].busy,
                 te, es, $sformatf("%s+%0d", nm, seq_tbl[i].off));
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Scoreboard drain: one edge count per rising edge, compare 1 ns later.
    always begin
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            check(e.nm, obs(e.d2), {e.rn, e.ar, e.busy, e.te, e.es});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, e4, b5;

        seq_tbl[0]  = '{1,  4'b0000, 1'b0, 1'b1};
        seq_tbl[1]  = '{16, 4'b0000, 1'b0, 1'b1};
        seq_tbl[2]  = '{17, 4'b0001, 1'b0, 1'b1};
        seq_tbl[3]  = '{26, 4'b0001, 1'b0, 1'b1};
        seq_tbl[4]  = '{27, 4'b0011, 1'b0, 1'b1};
        seq_tbl[5]  = '{36, 4'b0011, 1'b0, 1'b1};
        seq_tbl[6]  = '{37, 4'b0111, 1'b0, 1'b1};
        seq_tbl[7]  = '{46, 4'b0111, 1'b0, 1'b1};
        seq_tbl[8]  = '{47, 4'b1111, 1'b0, 1'b1};
        seq_tbl[9]  = '{48, 4'b1111, 1'b0, 1'b1};
        seq_tbl[10] = '{49, 4'b1111, 1'b1, 1'b0};

        bus1.sw_rst_req  = 1'b0;
        bus1.stage_ready = 4'b1111;
        bus2.sw_rst_req  = 1'b0;
        bus2.stage_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_dut1", obs(1'b0), {4'b0000, 1'b0, 1'b1, 1'b0, 4'd0});
        check("reset_dut2", obs(1'b1), {4'b0000, 1'b0, 1'b1, 1'b0, 4'd0});

        // 1: power-on, all ready
        b = cyc;
        push_tbl(b, 1'b0, 4'd0, "t1");
        rst1 = 1'b0;
        wait_until(b + 49);

        // 2: stage 2 never ready -> timeout
        rst1 = 1'b1;
        bus1.stage_ready = 4'b1011;
        @(negedge clk);
        b = cyc;
        push(1'b0, b + 37,  4'b0111, 1'b0, 1'b1, 1'b0, 4'd0, "t2_rel2");
        push(1'b0, b + 291, 4'b0111, 1'b0, 1'b1, 1'b0, 4'd0, "t2_pre_to");
        push(1'b0, b + 292, 4'b0111, 1'b0, 1'b1, 1'b1, 4'd2, "t2_timeout");
        push(1'b0, b + 300, 4'b0111, 1'b0, 1'b1, 1'b1, 4'd2, "t2_gap_end");
        push(1'b0, b + 301, 4'b1111, 1'b0, 1'b1, 1'b1, 4'd2, "t2_rel3");
        push(1'b0, b + 302, 4'b1111, 1'b0, 1'b1, 1'b1, 4'd2, "t2_done_entry");
        push(1'b0, b + 303, 4'b1111, 1'b1, 1'b0, 1'b1, 4'd2, "t2_all_ready");
        rst1 = 1'b0;
        wait_until(b + 303);

        // 3: warm reset from DONE, error capture survives
        bus1.stage_ready = 4'b1111;
        bus1.sw_rst_req  = 1'b1;
        b = cyc + 1;
        push(1'b0, b, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd2, "t3_drop");
        push_tbl(b, 1'b1, 4'd2, "t3");
        wait_until(b);
        bus1.sw_rst_req = 1'b0;
        wait_until(b + 49);

        // 4: warm reset during GAP (held 3 edges), then one coinciding with
        //    the first ready sample of stage 0
        bus1.sw_rst_req = 1'b1;
        b = cyc + 1;
        e4 = b + 30;
        push(1'b0, b + 29, 4'b0011, 1'b0, 1'b1, 1'b1, 4'd2, "t4_in_gap");
        push(1'b0, e4,      4'b0000, 1'b0, 1'b1, 1'b1, 4'd2, "t4_drop");
        push(1'b0, e4 + 18, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd2, "t4_hold_stretch");
        push(1'b0, e4 + 19, 4'b0001, 1'b0, 1'b1, 1'b1, 4'd2, "t4_rel0");
        push(1'b0, e4 + 20, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd2, "t4_sw_beats_ready");
        wait_until(b);
        bus1.sw_rst_req = 1'b0;
        wait_until(e4 - 1);
        bus1.sw_rst_req = 1'b1;
        wait_until(e4 + 2);
        bus1.sw_rst_req = 1'b0;
        wait_until(e4 + 19);
        bus1.sw_rst_req = 1'b1;
        wait_until(e4 + 20);
        bus1.sw_rst_req  = 1'b0;
        bus1.stage_ready = 4'b1011;

        // 5: hard reset mid-WAIT_RDY, between clock edges
        b5 = e4 + 20;
        push(1'b0, b5 + 16, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd2, "t5_stretch");
        push(1'b0, b5 + 17, 4'b0001, 1'b0, 1'b1, 1'b1, 4'd2, "t5_rel0");
        push(1'b0, b5 + 37, 4'b0111, 1'b0, 1'b1, 1'b1, 4'd2, "t5_rel2");
        push(1'b0, b5 + 39, 4'b0111, 1'b0, 1'b1, 1'b1, 4'd2, "t5_waiting");
        wait_until(b5 + 39);
        #2 rst1 = 1'b1;
        #1 check("t5_async_reset", obs(1'b0), {4'b0000, 1'b0, 1'b1, 1'b0, 4'd0});

        // 6: single-stage minimal-timing instance
        @(negedge clk);
        b = cyc;
        push(1'b1, b + 1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, "t6_edge1");
        push(1'b1, b + 2, 4'b0001, 1'b0, 1'b1, 1'b0, 4'd0, "t6_rel0");
        push(1'b1, b + 3, 4'b0001, 1'b0, 1'b1, 1'b0, 4'd0, "t6_done_entry");
        push(1'b1, b + 4, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd0, "t6_all_ready");
        rst2 = 1'b0;
        wait_until(b + 4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained: %0d entries left, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Sits directly downstream of the reset bridge and consumes its synchronized reset.
- Stretches that reset for a fixed time, then releases NUM_STAGES per-block resets one at a time in order.
- Before each next release, waits for the current stage's ready acknowledge, bounded by a timeout.
- Supports a software-requested warm reset that re-runs the whole sequence.

Parameters:
- NUM_STAGES, 4, number of sequenced reset outputs (1..16)
- STRETCH_CYC, 16, cycles held in reset after sync_rst_n deasserts (≥1)
- GAP_CYC, 8, cycles between a stage's ready and the next stage's release (≥1)
- ACK_TIMEOUT, 255, maximum WAIT_RDY cycles before a timeout is flagged (≥1)
- CNT_W, 8, counter width; must hold max(STRETCH_CYC, GAP_CYC, ACK_TIMEOUT)

Ports:
- clk  in  1  system clock
- sync_rst_n  in  1  reset, asynchronous, active-high
- sw_rst_req  in  1  single-cycle warm-reset request, synchronous to clk
- stage_ready  in  NUM_STAGES  per-stage init-done, synchronous to clk; only the current index is sampled
- stage_rst_n  out  NUM_STAGES  per-stage resets, active-low, registered
- all_ready  out  1  high when every stage is released and the sequence is complete
- seq_busy  out  1  high while the sequence is in progress
- timeout_err  out  1  sticky ready-timeout flag
- err_stage  out  4  index of the most recent timed-out stage

Behaviour:
- Reset (sync_rst_n=1), asynchronous:
  - stage_rst_n all 0, all_ready 0, seq_busy 1, timeout_err 0, err_stage 0.
  - FSM=STRETCH, idx=0, cnt=0.
  - Reset asserting mid-sequence aborts immediately to these values.
- FSM states: STRETCH, RELEASE, WAIT_RDY, GAP, DONE.
- STRETCH: cnt increments each edge. At cnt==STRETCH_CYC-1, go to RELEASE.
  - Net effect: stage_rst_n[0] rises on the (STRETCH_CYC+1)th rising edge after sync_rst_n deasserts.
- RELEASE (1 cycle): set stage_rst_n[idx]=1, clear cnt, go to WAIT_RDY.
- WAIT_RDY, checked in this priority:
  - stage_ready[idx]=1 sampled: if idx==NUM_STAGES-1 go to DONE, else go to GAP with cnt=0.
  - Else if cnt==ACK_TIMEOUT-1: set timeout_err=1, err_stage=idx, then proceed exactly as if ready were seen (never hang).
  - Else cnt++.
- GAP: cnt++. At cnt==GAP_CYC-1, idx++ and go to RELEASE.
  - stage_rst_n[k+1] rises GAP_CYC+1 edges after the edge that sampled ready[k].
- DONE: all_ready=1 and seq_busy=0, registered, one edge after entry. The FSM stays in DONE.
- Stage outputs are monotonic during a sequence: released stages stay released. Ready of already-released stages is not monitored.
- sw_rst_req=1 in any state, highest priority after hard reset; on the next edge:
  - stage_rst_n all 0 simultaneously, all_ready 0, seq_busy 1.
  - idx=0, cnt=0, FSM=STRETCH.
  - timeout_err and err_stage are NOT cleared; only sync_rst_n clears them.
- sw_rst_req held high for multiple cycles keeps the FSM in STRETCH with cnt=0. Counting starts the cycle after it drops.
- sw_rst_req coinciding with the ready sample in WAIT_RDY: sw_rst_req wins.
- A ready already high when a stage is released is accepted on the first WAIT_RDY edge, i.e. 1 cycle after release.
- Counters never wrap: they are cleared on every state entry and compared with ==.

Decomposition:
- Package rst_seq_pkg:
  - state enum (STRETCH, RELEASE, WAIT_RDY, GAP, DONE)
  - IDX_W = $clog2(NUM_STAGES) function/constant
  - default timing constants
- Sub-module rst_seq_timer:
  - clearable up-counter with terminal-count compare input and a tc output
  - shared by the STRETCH, GAP and timeout phases
- Top module holds the FSM, idx register, output registers and error capture.

Test Plan:
1. Power-on, defaults, stage_ready tied to 4'b1111: stage_rst_n[0] rises 17 edges after sync_rst_n falls; stages 1..3 follow at 10-edge spacing; all_ready=1 one edge after stage 3's ready is sampled; timeout_err=0.
2. stage_ready[2] held 0: WAIT_RDY lasts 255 cycles, then timeout_err=1 and err_stage=2; stage 3 is released 9 edges later and all_ready=1 afterward.
3. sw_rst_req pulse in DONE: next edge stage_rst_n=4'b0000, all_ready=0, seq_busy=1; full re-sequence with identical timing to test 1; timeout_err from test 2 is still 1.
4. sw_rst_req during GAP after stage 1 (stage_rst_n=4'b0011): all outputs drop to 0 on the next edge and the sequence restarts from stage 0.
5. sync_rst_n asserted asynchronously mid-WAIT_RDY (off clock edge): stage_rst_n=0 and timeout_err=0 within 1 ns, with no clock edge needed.
6. NUM_STAGES=1, STRETCH_CYC=1, GAP_CYC=1: stage_rst_n[0] rises on the 2nd edge after deassertion; all_ready follows its ready sample by 1 edge.
